rvfi_trace_buffer: RTL and testbench
====================================

Name: rvfi_trace_buffer

Overview:
Sits directly downstream of the core's RVFI retirement port, alongside the RVVI driver in the trace bench, and consumes the same retirement stream. It captures each retired-instruction record into a FIFO and presents it to a log writer or reference-model checker over a valid/ready handshake. It also flags overflow, counts dropped records and checks that rvfi_order is monotonic.

Parameters:
DEPTH, 16, FIFO entries; power of 2, >= 2
CNT_W, 16, width of drop counter

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous reset, active-low
flush_i  in  1  synchronous flush: empties FIFO and clears status
rvfi_valid_i  in  1  retirement valid
rvfi_order_i  in  64  retirement order
rvfi_insn_i  in  32  instruction word
rvfi_trap_i  in  1  trap flag
rvfi_pc_rdata_i  in  32  PC of the retired instruction
rvfi_pc_wdata_i  in  32  next PC
rvfi_rd_addr_i  in  5  integer destination register
rvfi_rd_wdata_i  in  32  integer write data
rvfi_frd_wvalid_i  in  1  FP register write valid
rvfi_frd_addr_i  in  5  FP destination register
rvfi_frd_wdata_i  in  32  FP write data
out_valid_o  out  1  head record available
out_ready_i  in  1  consumer accepts the head record
out_rec_o  out  268  head record (trace_rec_t, packed)
count_o  out  $clog2(DEPTH)+1  current occupancy
overflow_o  out  1  sticky: a record was dropped
drop_cnt_o  out  CNT_W  dropped records, saturating
order_err_o  out  1  sticky: order discontinuity seen
order_err_val_o  out  64  order value of the first offending record

Behaviour:
- Reset (rst_n_i=0 at a clk_i edge): FIFO empty; every output 0; order-tracking state cleared to "no record seen". Reset mid-transfer discards all contents.
- Priority: reset > flush_i > push/pop. flush_i has the same effect as reset; a push in the same cycle is discarded.
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits and wrap naturally. Empty when rd_ptr==wr_ptr. Full when the index bits are equal and the MSBs differ. count_o = wr_ptr - rd_ptr.
- pop = out_valid_o & out_ready_i.
- push = rvfi_valid_i & (!full | pop). When full, a simultaneous pop frees the slot and the push is accepted in the same cycle.
- Drop: rvfi_valid_i & full & !pop. The record is lost, overflow_o is set, and drop_cnt_o increments, saturating at all-ones.
- Latency: a pushed record is visible at out_valid_o/out_rec_o on the next cycle; there is no combinational bypass. out_rec_o is the registered head and holds stable while out_valid_o=1 & out_ready_i=0.
- Empty: out_valid_o=0. A pop while empty is impossible by construction.
- Record sanitisation at push:
  - rd_addr==0 stores rd_wdata=0.
  - frd_wvalid=0 stores frd_addr=0 and frd_wdata=0.
- Order check, evaluated on every rvfi_valid_i including dropped records:
  - The first record after reset or flush loads expected = order+1.
  - Each later record with order != expected sets order_err_o. On the first error only, order_err_val_o captures the offending order.
  - expected is then reloaded to order+1 so a single gap flags once.
  - Arithmetic is 64-bit modulo.
- Sticky flags hold until reset or flush.

Decomposition:
- Shared package rvfi_trace_pkg:
  - trace_rec_t, packed in this field order: order, insn, trap, pc_rdata, pc_wdata, rd_addr, rd_wdata, frd_wvalid, frd_addr, frd_wdata.
  - TRACE_REC_W = 268.
- Sub-module trace_fifo_mem: DEPTH x TRACE_REC_W register array with a write port and a registered read at the head index.
- Top level owns the pointers, flag logic and order checker.

Test Plan:
- Retire orders 1..5 back-to-back with out_ready_i=1 -> out_valid_o rises one cycle after the first push; orders 1..5 emerge in sequence; count_o never exceeds 1; no flags set.
- out_ready_i=0, push 18 records with DEPTH=16 -> count_o=16; overflow_o=1; drop_cnt_o=2; releasing ready yields orders 1..16.
- FIFO full, then push and pop in the same cycle -> push accepted; count_o stays 16; drop_cnt_o unchanged.
- Orders 1,2,3,7,8 -> order_err_o=1 from the cycle after order 7 and order_err_val_o=7; order 8 raises no further error.
- rd_addr=0 with rd_wdata=0xDEADBEEF, and frd_wvalid=0 with frd_wdata=0x1234 -> out_rec_o shows rd_wdata=0 and frd_wdata=0.
- 5 records queued with flags set, then flush_i=1 concurrent with rvfi_valid_i -> next cycle count_o=0, out_valid_o=0, all flags and drop_cnt_o cleared; the concurrent record is absent.

Source files
------------

// File: rtl/rvfi_trace_pkg.sv
// Shared types for the RVFI trace buffer.
//   trace_rec_t  : one retired-instruction record, fields MSB-first in capture order
//   TRACE_REC_W  : width of the record as stored and presented to the consumer;
//                  the fields occupy the low bits, the reserved top bits are zero
package rvfi_trace_pkg;

    localparam int unsigned TRACE_REC_W = 268;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic        frd_wvalid;
        logic [4:0]  frd_addr;
        logic [31:0] frd_wdata;
    } trace_rec_t;

    localparam int unsigned TRACE_FIELDS_W = $bits(trace_rec_t);
    localparam int unsigned TRACE_PAD_W    = TRACE_REC_W - TRACE_FIELDS_W;

endpackage

// File: rtl/rvfi_trace_buffer_if.sv
// Bundle between the retirement source / trace consumer and the trace buffer.
//   rvfi_*          : retirement record from the core (master -> slave)
//   out_valid_o/out_ready_i/out_rec_o : head-record handshake toward the consumer
//   count_o, overflow_o, drop_cnt_o, order_err_o, order_err_val_o : status (slave -> master)
// Modports: master = bench/core side, slave = trace buffer.
interface rvfi_trace_buffer_if #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) ();
    import rvfi_trace_pkg::*;

    logic                     rvfi_valid_i;
    logic [63:0]              rvfi_order_i;
    logic [31:0]              rvfi_insn_i;
    logic                     rvfi_trap_i;
    logic [31:0]              rvfi_pc_rdata_i;
    logic [31:0]              rvfi_pc_wdata_i;
    logic [4:0]               rvfi_rd_addr_i;
    logic [31:0]              rvfi_rd_wdata_i;
    logic                     rvfi_frd_wvalid_i;
    logic [4:0]               rvfi_frd_addr_i;
    logic [31:0]              rvfi_frd_wdata_i;

    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [TRACE_REC_W-1:0]   out_rec_o;
    logic [$clog2(DEPTH):0]   count_o;
    logic                     overflow_o;
    logic [CNT_W-1:0]         drop_cnt_o;
    logic                     order_err_o;
    logic [63:0]              order_err_val_o;

    modport master (
        output rvfi_valid_i, rvfi_order_i, rvfi_insn_i, rvfi_trap_i, rvfi_pc_rdata_i,
               rvfi_pc_wdata_i, rvfi_rd_addr_i, rvfi_rd_wdata_i, rvfi_frd_wvalid_i,
               rvfi_frd_addr_i, rvfi_frd_wdata_i, out_ready_i,
        input  out_valid_o, out_rec_o, count_o, overflow_o, drop_cnt_o, order_err_o,
               order_err_val_o
    );

    modport slave (
        input  rvfi_valid_i, rvfi_order_i, rvfi_insn_i, rvfi_trap_i, rvfi_pc_rdata_i,
               rvfi_pc_wdata_i, rvfi_rd_addr_i, rvfi_rd_wdata_i, rvfi_frd_wvalid_i,
               rvfi_frd_addr_i, rvfi_frd_wdata_i, out_ready_i,
        output out_valid_o, out_rec_o, count_o, overflow_o, drop_cnt_o, order_err_o,
               order_err_val_o
    );

endinterface

// File: rtl/trace_fifo_mem.sv
// Record storage for the trace buffer with a registered head.
//   clk_i, rst_n_i (sync, active-low), clr_i : clock, reset, flush
//   wr_en_i, wr_idx_i, wr_data_i             : write port
//   rd_adv_i                                 : head is being popped this cycle
//   rd_idx_i                                 : head index after this cycle's pop
//   head_o                                   : registered head record
module trace_fifo_mem
    import rvfi_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       clr_i,
    input  logic                       wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]   wr_idx_i,
    input  logic [TRACE_REC_W-1:0]     wr_data_i,
    input  logic                       rd_adv_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
    output logic [TRACE_REC_W-1:0]     head_o
);

    logic [TRACE_REC_W-1:0] mem_q [DEPTH];
    logic [TRACE_REC_W-1:0] head_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // A write landing on the next head slot (FIFO empty, or draining its last entry)
    // is loaded straight into the head register, since the array read would be stale.
    // Otherwise the head only moves on a pop, so it stays stable while stalled.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr_i) begin
            head_q <= '0;
        end else if (wr_en_i && (wr_idx_i == rd_idx_i)) begin
            head_q <= wr_data_i;
        end else if (rd_adv_i) begin
            head_q <= mem_q[rd_idx_i];
        end
    end

    assign head_o = head_q;

endmodule

// File: rtl/rvfi_trace_buffer.sv
// Captures RVFI retirement records into a FIFO and presents them over valid/ready.
//   clk_i   : clock
//   rst_n_i : synchronous reset, active-low
//   flush_i : synchronous flush, same effect as reset
//   bus     : retirement input, head handshake and status (slave modport)
// Also tracks overflow, a saturating drop count and rvfi_order continuity.
module rvfi_trace_buffer
    import rvfi_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                flush_i,
    rvfi_trace_buffer_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q, rd_ptr_inc, wr_ptr_inc;
    logic                   empty, full, pop, push, drop;
    logic [IDX_W-1:0]       rd_idx_next;
    trace_rec_t             rec_in;
    logic [TRACE_REC_W-1:0] wr_data, head;
    logic                   overflow_q;
    logic [CNT_W-1:0]       drop_cnt_q;
    logic                   seen_q, err_q;
    logic [63:0]            expected_q, err_val_q;

    assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);
    assign wr_ptr_inc = wr_ptr_q + PTR_W'(1);
    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (rd_ptr_q[IDX_W-1:0] == wr_ptr_q[IDX_W-1:0]) &&
                   (rd_ptr_q[IDX_W] != wr_ptr_q[IDX_W]);
    assign pop   = !empty && bus.out_ready_i;
    assign push  = bus.rvfi_valid_i && (!full || pop);
    assign drop  = bus.rvfi_valid_i && full && !pop;
    assign rd_idx_next = pop ? rd_ptr_inc[IDX_W-1:0] : rd_ptr_q[IDX_W-1:0];

    // Don't-care data fields are zeroed so logs compare cleanly against a reference model.
    always_comb begin
        rec_in            = '0;
        rec_in.order      = bus.rvfi_order_i;
        rec_in.insn       = bus.rvfi_insn_i;
        rec_in.trap       = bus.rvfi_trap_i;
        rec_in.pc_rdata   = bus.rvfi_pc_rdata_i;
        rec_in.pc_wdata   = bus.rvfi_pc_wdata_i;
        rec_in.rd_addr    = bus.rvfi_rd_addr_i;
        rec_in.rd_wdata   = (bus.rvfi_rd_addr_i == 5'd0) ? 32'd0 : bus.rvfi_rd_wdata_i;
        rec_in.frd_wvalid = bus.rvfi_frd_wvalid_i;
        rec_in.frd_addr   = bus.rvfi_frd_wvalid_i ? bus.rvfi_frd_addr_i : 5'd0;
        rec_in.frd_wdata  = bus.rvfi_frd_wvalid_i ? bus.rvfi_frd_wdata_i : 32'd0;
    end

    assign wr_data = {{TRACE_PAD_W{1'b0}}, rec_in};

    trace_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (flush_i),
        .wr_en_i   (push),
        .wr_idx_i  (wr_ptr_q[IDX_W-1:0]),
        .wr_data_i (wr_data),
        .rd_adv_i  (pop),
        .rd_idx_i  (rd_idx_next),
        .head_o    (head)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_inc;
            if (pop)  rd_ptr_q <= rd_ptr_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

    // Checked on every retirement, dropped or not; reloading expected after a gap
    // means one discontinuity flags once rather than on every later record.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            seen_q     <= 1'b0;
            expected_q <= '0;
            err_q      <= 1'b0;
            err_val_q  <= '0;
        end else if (bus.rvfi_valid_i) begin
            if (seen_q && (bus.rvfi_order_i != expected_q)) begin
                err_q <= 1'b1;
                if (!err_q) err_val_q <= bus.rvfi_order_i;
            end
            expected_q <= bus.rvfi_order_i + 64'd1;
            seen_q     <= 1'b1;
        end
    end

    assign bus.out_valid_o     = !empty;
    assign bus.out_rec_o       = head;
    assign bus.count_o         = wr_ptr_q - rd_ptr_q;
    assign bus.overflow_o      = overflow_q;
    assign bus.drop_cnt_o      = drop_cnt_q;
    assign bus.order_err_o     = err_q;
    assign bus.order_err_val_o = err_val_q;

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Bench for rvfi_trace_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rvfi_trace_buffer;
    import rvfi_trace_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    always #5 clk = ~clk;

    rvfi_trace_buffer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    rvfi_trace_buffer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .flush_i (flush),
        .bus     (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [267:0] act, input logic [267:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model state
    logic [267:0] m_q [$];
    bit           m_ovf;
    int           m_drop;
    bit           m_seen;
    logic [63:0]  m_exp;
    bit           m_err;
    logic [63:0]  m_errval;
    bit           checking = 1'b0;

    function automatic logic [267:0] model_rec();
        logic [31:0] rdw, fdw;
        logic [4:0]  fda;
        rdw = (bus.rvfi_rd_addr_i == 5'd0) ? 32'd0 : bus.rvfi_rd_wdata_i;
        fda = bus.rvfi_frd_wvalid_i ? bus.rvfi_frd_addr_i : 5'd0;
        fdw = bus.rvfi_frd_wvalid_i ? bus.rvfi_frd_wdata_i : 32'd0;
        return {32'd0, bus.rvfi_order_i, bus.rvfi_insn_i, bus.rvfi_trap_i, bus.rvfi_pc_rdata_i,
                bus.rvfi_pc_wdata_i, bus.rvfi_rd_addr_i, rdw, bus.rvfi_frd_wvalid_i, fda, fdw};
    endfunction

    task automatic model_step();
        bit pop, full;
        if (!rst_n || flush) begin
            m_q.delete();
            m_ovf = 0; m_drop = 0; m_seen = 0; m_exp = '0; m_err = 0; m_errval = '0;
            return;
        end
        pop  = (m_q.size() != 0) && bus.out_ready_i;
        full = (m_q.size() == DEPTH);
        if (bus.rvfi_valid_i) begin
            if (m_seen && bus.rvfi_order_i != m_exp) begin
                if (!m_err) m_errval = bus.rvfi_order_i;
                m_err = 1;
            end
            m_exp  = bus.rvfi_order_i + 64'd1;
            m_seen = 1;
        end
        if (pop) void'(m_q.pop_front());
        if (bus.rvfi_valid_i) begin
            if (!full || pop) m_q.push_back(model_rec());
            else begin
                m_ovf = 1;
                if (m_drop < (1 << CNT_W) - 1) m_drop++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("out_valid", bus.out_valid_o, m_q.size() != 0);
            check("count", bus.count_o, m_q.size());
            check("overflow", bus.overflow_o, m_ovf);
            check("drop_cnt", bus.drop_cnt_o, m_drop);
            check("order_err", bus.order_err_o, m_err);
            check("order_err_val", bus.order_err_val_o, m_errval);
            if (m_q.size() != 0) check("out_rec", bus.out_rec_o, m_q[0]);
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_rec(input logic [63:0] o);
        bus.rvfi_order_i      = o;
        bus.rvfi_insn_i       = 32'h0000_0013 | (o[31:0] << 7);
        bus.rvfi_trap_i       = o[3];
        bus.rvfi_pc_rdata_i   = 32'h8000_0000 + (o[31:0] << 2);
        bus.rvfi_pc_wdata_i   = 32'h8000_0004 + (o[31:0] << 2);
        bus.rvfi_rd_addr_i    = o[4:0];
        bus.rvfi_rd_wdata_i   = 32'hA5A5_0000 ^ o[31:0];
        bus.rvfi_frd_wvalid_i = o[0];
        bus.rvfi_frd_addr_i   = o[5:1];
        bus.rvfi_frd_wdata_i  = 32'h3F80_0000 + o[31:0];
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus.rvfi_valid_i = 1'b0;
        bus.out_ready_i  = 1'b0;
        set_rec(64'd0);
        cycle();
        cycle();
        // Reset state
        check("rst_valid", bus.out_valid_o, 1'b0);
        check("rst_count", bus.count_o, 0);
        check("rst_rec", bus.out_rec_o, 0);
        check("rst_err_val", bus.order_err_val_o, 0);
        checking = 1'b1;
        rst_n = 1'b1;
        cycle();

        // Back-to-back streaming with ready high
        bus.out_ready_i = 1'b1;
        for (int o = 1; o <= 5; o++) begin
            set_rec(64'(o));
            bus.rvfi_valid_i = 1'b1;
            cycle();
            check("stream_valid", bus.out_valid_o, 1'b1);
            check("stream_order", bus.out_rec_o[235:172], o);
            check("stream_count", bus.count_o, 1);
        end
        bus.rvfi_valid_i = 1'b0;
        cycle();
        check("stream_drained", bus.out_valid_o, 1'b0);
        check("stream_no_err", bus.order_err_o, 1'b0);

        // Fill past capacity with ready low
        do_flush();
        bus.out_ready_i = 1'b0;
        for (int o = 1; o <= 18; o++) begin
            set_rec(64'(o));
            bus.rvfi_valid_i = 1'b1;
            cycle();
        end
        bus.rvfi_valid_i = 1'b0;
        cycle();
        check("fill_count", bus.count_o, 16);
        check("fill_overflow", bus.overflow_o, 1'b1);
        check("fill_drops", bus.drop_cnt_o, 2);
        check("fill_head", bus.out_rec_o[235:172], 1);

        // Full: push and pop in the same cycle
        set_rec(64'd19);
        bus.rvfi_valid_i = 1'b1;
        bus.out_ready_i  = 1'b1;
        cycle();
        bus.rvfi_valid_i = 1'b0;
        check("fullpp_count", bus.count_o, 16);
        check("fullpp_drops", bus.drop_cnt_o, 2);
        for (int k = 2; k <= 16; k++) begin
            check("drain_order", bus.out_rec_o[235:172], k);
            cycle();
        end
        check("drain_last", bus.out_rec_o[235:172], 19);
        cycle();
        check("drain_empty", bus.out_valid_o, 1'b0);

        // Order discontinuity 1,2,3,7,8
        do_flush();
        bus.out_ready_i = 1'b1;
        begin
            logic [63:0] ords [5];
            ords = '{64'd1, 64'd2, 64'd3, 64'd7, 64'd8};
            for (int i = 0; i < 5; i++) begin
                set_rec(ords[i]);
                bus.rvfi_valid_i = 1'b1;
                cycle();
                if (i == 2) check("gap_before", bus.order_err_o, 1'b0);
                if (i >= 3) begin
                    check("gap_err", bus.order_err_o, 1'b1);
                    check("gap_val", bus.order_err_val_o, 7);
                end
            end
        end
        bus.rvfi_valid_i = 1'b0;
        cycle();

        // Sanitisation of unused write data
        do_flush();
        bus.out_ready_i = 1'b0;
        set_rec(64'd1);
        bus.rvfi_rd_addr_i    = 5'd0;
        bus.rvfi_rd_wdata_i   = 32'hDEAD_BEEF;
        bus.rvfi_frd_wvalid_i = 1'b0;
        bus.rvfi_frd_addr_i   = 5'd7;
        bus.rvfi_frd_wdata_i  = 32'h0000_1234;
        bus.rvfi_valid_i = 1'b1;
        cycle();
        bus.rvfi_valid_i = 1'b0;
        check("san_rd_wdata", bus.out_rec_o[69:38], 0);
        check("san_frd_addr", bus.out_rec_o[36:32], 0);
        check("san_frd_wdata", bus.out_rec_o[31:0], 0);
        check("san_pad", bus.out_rec_o[267:236], 0);
        check("san_pc", bus.out_rec_o[138:107], 32'h8000_0004);
        cycle();

        // Flags set, 5 queued, then flush with a concurrent record
        do_flush();
        bus.out_ready_i = 1'b0;
        for (int o = 1; o <= 17; o++) begin
            set_rec((o == 17) ? 64'd40 : 64'(o));
            bus.rvfi_valid_i = 1'b1;
            cycle();
        end
        bus.rvfi_valid_i = 1'b0;
        bus.out_ready_i  = 1'b1;
        for (int i = 0; i < 11; i++) cycle();
        bus.out_ready_i = 1'b0;
        check("pre_flush_count", bus.count_o, 5);
        check("pre_flush_err_val", bus.order_err_val_o, 40);
        set_rec(64'd100);
        bus.rvfi_valid_i = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        bus.rvfi_valid_i = 1'b0;
        check("flush_count", bus.count_o, 0);
        check("flush_valid", bus.out_valid_o, 1'b0);
        check("flush_ovf", bus.overflow_o, 1'b0);
        check("flush_drops", bus.drop_cnt_o, 0);
        check("flush_err", bus.order_err_o, 1'b0);
        cycle();
        check("flush_absent", bus.count_o, 0);
        set_rec(64'd500);
        bus.rvfi_valid_i = 1'b1;
        cycle();
        bus.rvfi_valid_i = 1'b0;
        check("flush_fresh_order", bus.order_err_o, 1'b0);
        check("flush_fresh_count", bus.count_o, 1);

        // Reset mid-transfer discards contents
        set_rec(64'd501);
        bus.rvfi_valid_i = 1'b1;
        cycle();
        bus.rvfi_valid_i = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("midrst_count", bus.count_o, 0);
        check("midrst_rec", bus.out_rec_o, 0);
        cycle();

        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
